vertex_fetch_ctrl: RTL and testbench
====================================

VERTEX_FETCH_CTRL -- requirements
Module: vertex_fetch_ctrl

Interface
REQ-001 SHALL have parameter VW, default 48, meaning the vertex word width in bits.
REQ-002 SHALL have parameter MAXTRI, default 8'd36, meaning the maximum number of triangles accepted per frame.
REQ-003 SHALL have port clk100, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port nReset, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port nextFrame, input, 1 bit: frame start pulse.
REQ-006 SHALL have port VertexBuffer_PreCalc_pop, output, 1 bit: vertex pop request.
REQ-007 SHALL have port VertexBuffer_PreCalc_empty, input, 1 bit: vertex source empty.
REQ-008 SHALL have port VertexBuffer_PreCalc_data, input, VW bits: vertex word, valid the cycle after a pop.
REQ-009 SHALL have port PreCalc_TriangleFIFO_WriteData, output, 3*VW bits: packed triangle {v2,v1,v0}.
REQ-010 SHALL have port PreCalc_TriangleFIFO_push, output, 1 bit: triangle write strobe.
REQ-011 SHALL have port PreCalc_TriangleFIFO_wait, input, 1 bit: FIFO backpressure.
REQ-012 SHALL have port frameDone, output, 1 bit: frame fully fetched.
REQ-013 SHALL have port partialDrop, output, 1 bit: sticky flag, frame ended with an incomplete triangle.
REQ-014 SHALL have port triCount, output, 8 bits: triangles pushed in the current frame.

Function
REQ-015 SHALL implement FSM states IDLE, CHECK, POP, CAPTURE, PUSH, DONE.
REQ-016 IDLE SHALL hold until nextFrame=1, then go to CHECK with slot=0, triCount=0, partialDrop=0.
REQ-017 CHECK SHALL go to DONE if empty=1 or triCount==MAXTRI; otherwise it SHALL go to POP.
REQ-018 POP SHALL assert pop for exactly one cycle, then go to CAPTURE; pop SHALL be low in every other state.
REQ-019 CAPTURE SHALL store data into vertex register slot[1:0], then increment slot; if slot was 2 it SHALL go to PUSH with slot=0, otherwise to CHECK.
REQ-020 PUSH SHALL drive push = !wait combinationally, with WriteData = {v2,v1,v0} stable throughout PUSH.
REQ-021 In PUSH, when wait=0 the block SHALL increment triCount and go to CHECK; when wait=1 it SHALL hold state and data.
REQ-022 Entering DONE with slot!=0 SHALL set partialDrop=1 and discard the held vertices.
REQ-023 DONE SHALL assert frameDone=1 and hold until nextFrame.
REQ-024 nextFrame=1 in any state SHALL take priority: next state CHECK, slot/triCount/partialDrop cleared, push forced low that cycle, any held vertices discarded.
REQ-025 Vertex data popped before a nextFrame SHALL NOT be captured if nextFrame coincides with CAPTURE.
REQ-026 Minimum cost SHALL be 10 cycles per triangle when wait=0 and the source is never empty.
REQ-027 triCount SHALL saturate at MAXTRI and never wrap.
REQ-028 WriteData SHALL be 0 outside PUSH.

Reset
REQ-029 nReset=0 SHALL asynchronously force IDLE, pop=0, push=0, frameDone=0, partialDrop=0, triCount=0, slot=0, and vertex registers=0.
REQ-030 Reset deassertion SHALL be synchronized to clk100, and the first state change SHALL occur no earlier than the second rising edge after release.

Structure
REQ-031 State encoding, VW default, and MAXTRI default SHALL live in shared package gpu_pkg.
REQ-032 The block SHALL instantiate one sub-module, vf_reset_sync, a two-flop synchronizer for nReset deassertion.
REQ-033 The block SHALL be single-clock, with no multicycle paths.

Verification
REQ-034 Reset, then nextFrame, with a 6-vertex source 0x1..0x6 and wait=0 -> two pushes, WriteData 0x3_2_1 then 0x6_5_4 (VW-packed); triCount=2; frameDone=1.
REQ-035 A 4-vertex source -> one push, then DONE with partialDrop=1 and triCount=1.
REQ-036 wait held high for 5 cycles in PUSH -> push low, WriteData stable, no extra pop; a single push when wait falls.
REQ-037 nextFrame asserted during CAPTURE of vertex 2 -> no push; restart from slot 0; the next triangle uses only new vertices.
REQ-038 A source of 200 vertices with MAXTRI=36 -> exactly 36 pushes, 108 pops, and frameDone=1.
REQ-039 nReset pulsed low mid-PUSH -> push drops immediately (asynchronously); all outputs return to reset values.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg
//   Shared definitions for the vertex fetch path: vertex width and
//   per-frame triangle limit defaults, the fetch FSM state encoding and a
//   saturating counter helper.
package gpu_pkg;

  localparam int unsigned VW_DEF     = 48;
  localparam logic [7:0]  MAXTRI_DEF = 8'd36;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    POP     = 3'd2,
    CAPTURE = 3'd3,
    PUSH    = 3'd4,
    DONE    = 3'd5
  } vfState_t;

  // Increment that sticks at the limit instead of wrapping.
  function automatic logic [7:0] satInc8(input logic [7:0] value, input logic [7:0] limit);
    logic [7:0] result;
    if (value >= limit) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/vertex_fetch_ctrl_if.sv
// vertex_fetch_ctrl_if
//   Groups the frame control, vertex source and triangle FIFO signals of
//   the vertex fetch controller.
//   master : the fetch controller (drives pop, WriteData, push, status)
//   slave  : the surrounding pipeline (drives nextFrame, empty, data, wait)
interface vertex_fetch_ctrl_if
  import gpu_pkg::*;
#(
  parameter int unsigned VW = VW_DEF
);

  logic              nextFrame;
  logic              VertexBuffer_PreCalc_pop;
  logic              VertexBuffer_PreCalc_empty;
  logic [VW-1:0]     VertexBuffer_PreCalc_data;
  logic [3*VW-1:0]   PreCalc_TriangleFIFO_WriteData;
  logic              PreCalc_TriangleFIFO_push;
  logic              PreCalc_TriangleFIFO_wait;
  logic              frameDone;
  logic              partialDrop;
  logic [7:0]        triCount;

  modport master (
    input  nextFrame,
    output VertexBuffer_PreCalc_pop,
    input  VertexBuffer_PreCalc_empty,
    input  VertexBuffer_PreCalc_data,
    output PreCalc_TriangleFIFO_WriteData,
    output PreCalc_TriangleFIFO_push,
    input  PreCalc_TriangleFIFO_wait,
    output frameDone,
    output partialDrop,
    output triCount
  );

  modport slave (
    output nextFrame,
    input  VertexBuffer_PreCalc_pop,
    output VertexBuffer_PreCalc_empty,
    output VertexBuffer_PreCalc_data,
    input  PreCalc_TriangleFIFO_WriteData,
    input  PreCalc_TriangleFIFO_push,
    output PreCalc_TriangleFIFO_wait,
    input  frameDone,
    input  partialDrop,
    input  triCount
  );

endinterface

// File: rtl/vf_reset_sync.sv
// vf_reset_sync
//   Two-flop reset synchronizer: assertion is asynchronous, release is
//   aligned to clk100 two rising edges after nReset goes high.
//   clk100   : clock
//   nReset   : raw asynchronous active-low reset
//   rstSyncN : synchronized active-low reset
module vf_reset_sync (
  input  logic clk100,
  input  logic nReset,
  output logic rstSyncN
);

  logic stage1_r;
  logic stage2_r;

  // Shift a one through two flops after reset release.
  always_ff @(posedge clk100 or negedge nReset) begin
    if (!nReset) begin
      stage1_r <= 1'b0;
      stage2_r <= 1'b0;
    end else begin
      stage1_r <= 1'b1;
      stage2_r <= stage1_r;
    end
  end

  assign rstSyncN = stage2_r;

endmodule

// File: rtl/vertex_fetch_ctrl.sv
// vertex_fetch_ctrl
//   Pops vertices one at a time from the vertex buffer, assembles groups of
//   three into a triangle {v2,v1,v0} and pushes it into the triangle FIFO,
//   up to MAXTRI triangles per frame. A nextFrame pulse restarts the frame
//   from any state.
//   clk100 : clock, rising edge
//   nReset : asynchronous active-low reset
//   bus    : frame control, vertex source and triangle FIFO signals
module vertex_fetch_ctrl
  import gpu_pkg::*;
#(
  parameter int unsigned VW     = VW_DEF,
  parameter logic [7:0]  MAXTRI = MAXTRI_DEF
) (
  input logic                 clk100,
  input logic                 nReset,
  vertex_fetch_ctrl_if.master bus
);

  logic          rstSyncN_s;

  vfState_t      state_r,       stateNext_s;
  logic [1:0]    slot_r,        slotNext_s;
  logic [7:0]    triCount_r,    triCountNext_s;
  logic          partialDrop_r, partialDropNext_s;
  logic [VW-1:0] v0_r,          v0Next_s;
  logic [VW-1:0] v1_r,          v1Next_s;
  logic [VW-1:0] v2_r,          v2Next_s;

  vf_reset_sync uResetSync (
    .clk100   (clk100),
    .nReset   (nReset),
    .rstSyncN (rstSyncN_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk100 or negedge rstSyncN_s) begin
    if (!rstSyncN_s) begin
      state_r       <= IDLE;
      slot_r        <= 2'd0;
      triCount_r    <= 8'd0;
      partialDrop_r <= 1'b0;
      v0_r          <= {VW{1'b0}};
      v1_r          <= {VW{1'b0}};
      v2_r          <= {VW{1'b0}};
    end else begin
      state_r       <= stateNext_s;
      slot_r        <= slotNext_s;
      triCount_r    <= triCountNext_s;
      partialDrop_r <= partialDropNext_s;
      v0_r          <= v0Next_s;
      v1_r          <= v1Next_s;
      v2_r          <= v2Next_s;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    stateNext_s       = state_r;
    slotNext_s        = slot_r;
    triCountNext_s    = triCount_r;
    partialDropNext_s = partialDrop_r;
    v0Next_s          = v0_r;
    v1Next_s          = v1_r;
    v2Next_s          = v2_r;

    if (bus.nextFrame) begin
      // A new frame wins over everything, including a pending capture.
      stateNext_s       = CHECK;
      slotNext_s        = 2'd0;
      triCountNext_s    = 8'd0;
      partialDropNext_s = 1'b0;
      v0Next_s          = {VW{1'b0}};
      v1Next_s          = {VW{1'b0}};
      v2Next_s          = {VW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          stateNext_s = IDLE;
        end
        CHECK: begin
          if (bus.VertexBuffer_PreCalc_empty || (triCount_r == MAXTRI)) begin
            stateNext_s = DONE;
            if (slot_r != 2'd0) begin
              // Frame ended mid-triangle: flag it and drop the leftovers.
              partialDropNext_s = 1'b1;
              slotNext_s        = 2'd0;
              v0Next_s          = {VW{1'b0}};
              v1Next_s          = {VW{1'b0}};
              v2Next_s          = {VW{1'b0}};
            end else begin
              partialDropNext_s = partialDrop_r;
            end
          end else begin
            stateNext_s = POP;
          end
        end
        POP: begin
          stateNext_s = CAPTURE;
        end
        CAPTURE: begin
          case (slot_r)
            2'd0:    v0Next_s = bus.VertexBuffer_PreCalc_data;
            2'd1:    v1Next_s = bus.VertexBuffer_PreCalc_data;
            2'd2:    v2Next_s = bus.VertexBuffer_PreCalc_data;
            default: v0Next_s = v0_r;
          endcase
          if (slot_r == 2'd2) begin
            stateNext_s = PUSH;
            slotNext_s  = 2'd0;
          end else begin
            stateNext_s = CHECK;
            slotNext_s  = slot_r + 2'd1;
          end
        end
        PUSH: begin
          if (!bus.PreCalc_TriangleFIFO_wait) begin
            stateNext_s    = CHECK;
            triCountNext_s = satInc8(triCount_r, MAXTRI);
          end else begin
            stateNext_s = PUSH;
          end
        end
        DONE: begin
          stateNext_s = DONE;
        end
        default: begin
          stateNext_s = IDLE;
        end
      endcase
    end
  end

  // Push follows wait combinationally so a released FIFO is written at once.
  assign bus.VertexBuffer_PreCalc_pop       = (state_r == POP);
  assign bus.PreCalc_TriangleFIFO_push      = (state_r == PUSH) && !bus.PreCalc_TriangleFIFO_wait
                                              && !bus.nextFrame;
  assign bus.PreCalc_TriangleFIFO_WriteData = (state_r == PUSH) ? {v2_r, v1_r, v0_r}
                                                                : {(3*VW){1'b0}};
  assign bus.frameDone                      = (state_r == DONE);
  assign bus.partialDrop                    = partialDrop_r;
  assign bus.triCount                       = triCount_r;

endmodule

// File: tb/tb_vertex_fetch_ctrl.sv
// tb_vertex_fetch_ctrl
//   Directed bench for vertex_fetch_ctrl with a counting vertex source and
//   a push logger on the triangle FIFO side.
module tb_vertex_fetch_ctrl;
  import gpu_pkg::*;

  localparam int VW = 48;

  logic clk100 = 1'b0;
  logic nReset = 1'b0;

  vertex_fetch_ctrl_if #(.VW(VW)) bus ();

  vertex_fetch_ctrl #(.VW(VW), .MAXTRI(8'd36)) dut (
    .clk100 (clk100),
    .nReset (nReset),
    .bus    (bus)
  );

  always #5 clk100 = ~clk100;

  int checks = 0;
  int passes = 0;

  int srcCount   = 0;
  int srcBase    = 0;
  logic srcRestart = 1'b0;
  int srcIdx     = 0;
  int popCnt     = 0;
  int pushCnt    = 0;
  int cyc        = 0;
  logic [3*VW-1:0] pushLog [0:63];
  int pushCyc [0:63];

  assign bus.VertexBuffer_PreCalc_empty = (srcIdx >= srcCount);

  // Vertex source returning base+index+1, plus push logging.
  always @(posedge clk100) begin
    cyc <= cyc + 1;
    if (srcRestart) begin
      srcIdx  <= 0;
      popCnt  <= 0;
      pushCnt <= 0;
    end else begin
      if (bus.VertexBuffer_PreCalc_pop) begin
        bus.VertexBuffer_PreCalc_data <= VW'(srcBase + srcIdx + 1);
        srcIdx <= srcIdx + 1;
        popCnt <= popCnt + 1;
      end
      if (bus.PreCalc_TriangleFIFO_push && pushCnt < 64) begin
        pushLog[pushCnt] <= bus.PreCalc_TriangleFIFO_WriteData;
        pushCyc[pushCnt] <= cyc;
        pushCnt <= pushCnt + 1;
      end
    end
  end

  function automatic logic [3*VW-1:0] tri3(input int a, input int b, input int c);
    logic [VW-1:0] x0, x1, x2;
    x0 = VW'(a);
    x1 = VW'(b);
    x2 = VW'(c);
    return {x2, x1, x0};
  endfunction

  task automatic startFrame(input int count, input int base);
    @(negedge clk100);
    srcCount      = count;
    srcBase       = base;
    srcRestart    = 1'b1;
    bus.nextFrame = 1'b1;
    @(negedge clk100);
    srcRestart    = 1'b0;
    bus.nextFrame = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.frameDone) break;
      @(negedge clk100);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk100);
    checks++; if (bus.VertexBuffer_PreCalc_pop !== 1'b0) $display("FAIL reset_pop got %0b want 0", bus.VertexBuffer_PreCalc_pop); else passes++;
    checks++; if (bus.PreCalc_TriangleFIFO_push !== 1'b0) $display("FAIL reset_push got %0b want 0", bus.PreCalc_TriangleFIFO_push); else passes++;
    checks++; if (bus.PreCalc_TriangleFIFO_WriteData !== {(3*VW){1'b0}}) $display("FAIL reset_wdata got %h want 0", bus.PreCalc_TriangleFIFO_WriteData); else passes++;
    checks++; if (bus.frameDone !== 1'b0) $display("FAIL reset_frameDone got %0b want 0", bus.frameDone); else passes++;
    checks++; if (bus.partialDrop !== 1'b0) $display("FAIL reset_partialDrop got %0b want 0", bus.partialDrop); else passes++;
    checks++; if (bus.triCount !== 8'd0) $display("FAIL reset_triCount got %0d want 0", bus.triCount); else passes++;
  endtask

  // nextFrame covering only the first two edges after release must be ignored.
  task automatic test_sync_release;
    @(negedge clk100);
    nReset = 1'b1; srcCount = 6; srcBase = 0; srcRestart = 1'b1; bus.nextFrame = 1'b1;
    repeat (2) @(negedge clk100);
    srcRestart = 1'b0; bus.nextFrame = 1'b0;
    repeat (12) @(negedge clk100);
    checks++; if (popCnt !== 0) $display("FAIL sync_pops got %0d want 0", popCnt); else passes++;
    checks++; if (bus.frameDone !== 1'b0) $display("FAIL sync_frameDone got %0b want 0", bus.frameDone); else passes++;
  endtask

  task automatic test_basic;
    startFrame(6, 0);
    waitDone(100);
    checks++; if (bus.frameDone !== 1'b1) $display("FAIL basic_frameDone got %0b want 1", bus.frameDone); else passes++;
    checks++; if (pushCnt !== 2) $display("FAIL basic_pushes got %0d want 2", pushCnt); else passes++;
    checks++; if (pushLog[0] !== tri3(1, 2, 3)) $display("FAIL basic_tri0 got %h want %h", pushLog[0], tri3(1, 2, 3)); else passes++;
    checks++; if (pushLog[1] !== tri3(4, 5, 6)) $display("FAIL basic_tri1 got %h want %h", pushLog[1], tri3(4, 5, 6)); else passes++;
    checks++; if (bus.triCount !== 8'd2) $display("FAIL basic_triCount got %0d want 2", bus.triCount); else passes++;
    checks++; if (pushCyc[1] - pushCyc[0] !== 10) $display("FAIL basic_tri_period got %0d want 10", pushCyc[1] - pushCyc[0]); else passes++;
    checks++; if (bus.partialDrop !== 1'b0) $display("FAIL basic_partialDrop got %0b want 0", bus.partialDrop); else passes++;
    checks++; if (bus.PreCalc_TriangleFIFO_WriteData !== {(3*VW){1'b0}}) $display("FAIL basic_wdata_idle got %h want 0", bus.PreCalc_TriangleFIFO_WriteData); else passes++;
  endtask

  task automatic test_partial;
    startFrame(4, 0);
    waitDone(100);
    checks++; if (bus.frameDone !== 1'b1) $display("FAIL partial_frameDone got %0b want 1", bus.frameDone); else passes++;
    checks++; if (pushCnt !== 1) $display("FAIL partial_pushes got %0d want 1", pushCnt); else passes++;
    checks++; if (bus.partialDrop !== 1'b1) $display("FAIL partial_flag got %0b want 1", bus.partialDrop); else passes++;
    checks++; if (bus.triCount !== 8'd1) $display("FAIL partial_triCount got %0d want 1", bus.triCount); else passes++;
  endtask

  task automatic test_wait;
    bus.PreCalc_TriangleFIFO_wait = 1'b1;
    startFrame(3, 16);
    for (int i = 0; i < 40; i++) begin
      if (bus.PreCalc_TriangleFIFO_WriteData !== {(3*VW){1'b0}}) break;
      @(negedge clk100);
    end
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.PreCalc_TriangleFIFO_push !== 1'b0) $display("FAIL wait_push_low[%0d] got %0b want 0", i, bus.PreCalc_TriangleFIFO_push); else passes++;
      checks++; if (bus.PreCalc_TriangleFIFO_WriteData !== tri3(17, 18, 19)) $display("FAIL wait_wdata[%0d] got %h want %h", i, bus.PreCalc_TriangleFIFO_WriteData, tri3(17, 18, 19)); else passes++;
      @(negedge clk100);
    end
    checks++; if (popCnt !== 3) $display("FAIL wait_pops got %0d want 3", popCnt); else passes++;
    bus.PreCalc_TriangleFIFO_wait = 1'b0;
    #1;
    checks++; if (bus.PreCalc_TriangleFIFO_push !== 1'b1) $display("FAIL wait_release_push got %0b want 1", bus.PreCalc_TriangleFIFO_push); else passes++;
    waitDone(50);
    checks++; if (pushCnt !== 1) $display("FAIL wait_pushes got %0d want 1", pushCnt); else passes++;
    checks++; if (bus.triCount !== 8'd1) $display("FAIL wait_triCount got %0d want 1", bus.triCount); else passes++;
  endtask

  // Restart while the third vertex is being captured.
  task automatic test_restart;
    startFrame(100, 256);
    repeat (8) @(negedge clk100);
    checks++; if (popCnt !== 3) $display("FAIL restart_pops got %0d want 3", popCnt); else passes++;
    bus.nextFrame = 1'b1;
    @(negedge clk100);
    bus.nextFrame = 1'b0;
    checks++; if (pushCnt !== 0) $display("FAIL restart_no_push got %0d want 0", pushCnt); else passes++;
    waitDone(600);
    checks++; if (pushLog[0] !== tri3(260, 261, 262)) $display("FAIL restart_tri0 got %h want %h", pushLog[0], tri3(260, 261, 262)); else passes++;
    checks++; if (bus.triCount !== 8'd32) $display("FAIL restart_triCount got %0d want 32", bus.triCount); else passes++;
    checks++; if (bus.partialDrop !== 1'b1) $display("FAIL restart_partialDrop got %0b want 1", bus.partialDrop); else passes++;
  endtask

  task automatic test_maxtri;
    startFrame(200, 0);
    waitDone(1000);
    checks++; if (bus.frameDone !== 1'b1) $display("FAIL max_frameDone got %0b want 1", bus.frameDone); else passes++;
    checks++; if (pushCnt !== 36) $display("FAIL max_pushes got %0d want 36", pushCnt); else passes++;
    checks++; if (popCnt !== 108) $display("FAIL max_pops got %0d want 108", popCnt); else passes++;
    checks++; if (bus.triCount !== 8'd36) $display("FAIL max_triCount got %0d want 36", bus.triCount); else passes++;
    checks++; if (pushLog[35] !== tri3(106, 107, 108)) $display("FAIL max_last_tri got %h want %h", pushLog[35], tri3(106, 107, 108)); else passes++;
    checks++; if (bus.partialDrop !== 1'b0) $display("FAIL max_partialDrop got %0b want 0", bus.partialDrop); else passes++;
  endtask

  task automatic test_reset_mid_push;
    startFrame(6, 32);
    for (int i = 0; i < 60; i++) begin
      if (pushCnt == 1 && bus.PreCalc_TriangleFIFO_WriteData !== {(3*VW){1'b0}}) break;
      @(negedge clk100);
    end
    checks++; if (bus.PreCalc_TriangleFIFO_push !== 1'b1) $display("FAIL midpush_push_before got %0b want 1", bus.PreCalc_TriangleFIFO_push); else passes++;
    checks++; if (bus.triCount !== 8'd1) $display("FAIL midpush_triCount_before got %0d want 1", bus.triCount); else passes++;
    #1 nReset = 1'b0;
    #1;
    checks++; if (bus.PreCalc_TriangleFIFO_push !== 1'b0) $display("FAIL midpush_push_async got %0b want 0", bus.PreCalc_TriangleFIFO_push); else passes++;
    checks++; if (bus.PreCalc_TriangleFIFO_WriteData !== {(3*VW){1'b0}}) $display("FAIL midpush_wdata got %h want 0", bus.PreCalc_TriangleFIFO_WriteData); else passes++;
    checks++; if (bus.triCount !== 8'd0) $display("FAIL midpush_triCount got %0d want 0", bus.triCount); else passes++;
    checks++; if (bus.VertexBuffer_PreCalc_pop !== 1'b0) $display("FAIL midpush_pop got %0b want 0", bus.VertexBuffer_PreCalc_pop); else passes++;
    checks++; if (bus.frameDone !== 1'b0) $display("FAIL midpush_frameDone got %0b want 0", bus.frameDone); else passes++;
    checks++; if (bus.partialDrop !== 1'b0) $display("FAIL midpush_partialDrop got %0b want 0", bus.partialDrop); else passes++;
    repeat (2) @(negedge clk100);
    nReset = 1'b1;
    repeat (3) @(negedge clk100);
  endtask

  initial begin
    bus.nextFrame = 1'b0;
    bus.PreCalc_TriangleFIFO_wait = 1'b0;
    test_reset();
    test_sync_release();
    test_basic();
    test_partial();
    test_wait();
    test_restart();
    test_maxtri();
    test_reset_mid_push();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
